// File: rtl/alu_exec_pkg.sv
`timescale 1ns/1ps
// alu_exec_pkg: shared opcode encodings and FSM state type for the ALU execute stage.
// Both the request side (alu_control) and alu_exec import this package so the
// opcode encoding has a single source.
package alu_exec_pkg;

  localparam int unsigned ALU_OP_WIDTH = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 3'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 3'd1;  // A - B
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 3'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 3'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 3'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SHL = 3'd5;  // A << B[4:0]
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SHR = 3'd6;  // logical A >> B[4:0]
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL = 3'd7;  // low WIDTH bits of A*B

  typedef enum logic {
    StIdle,
    StMulRun
  } alu_state_e;

endpackage

// File: rtl/alu_exec_seq_multiplier.sv
`timescale 1ns/1ps
// seq_multiplier: iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Retires MUL_STEPS bits of b per cycle, LSB first, for WIDTH/MUL_STEPS cycles after load.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        capture a/b, clear accumulator, start counting
//   a, b        operands (sampled only on load)
//   busy        high from the cycle after load until the last step completes
//   done        combinational: high in the cycle whose step is the last one
//   product_lo  combinational accumulator-after-this-step; valid when done=1
module seq_multiplier #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MUL_STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);

  localparam int unsigned Count = WIDTH / MUL_STEPS;
  localparam int unsigned CntW  = $clog2(Count + 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  // Sum of the shifted multiplicand copies selected by the low MUL_STEPS bits of b.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < int'(MUL_STEPS); j++) begin
      if (r_b[j]) begin
        w_partial = w_partial + (r_a << j);
      end
    end
  end

  assign w_acc_next = r_acc + w_partial;
  assign w_last     = r_busy && (r_cnt == CntW'(1));

  assign busy       = r_busy;
  assign done       = w_last;
  assign product_lo = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (load) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= '0;
      r_cnt  <= CntW'(Count);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_a   <= r_a << MUL_STEPS;
      r_b   <= r_b >> MUL_STEPS;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CntW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
`timescale 1ns/1ps
// alu_exec: execute-side responder for the ALU operand/opcode bundle.
// Single-cycle ops complete one cycle after start; MUL is handed to seq_multiplier and
// completes WIDTH/MUL_STEPS + 1 cycles after start. result/zero are registered and hold
// until the next done pulse.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            request; accepted when busy=0
//   alu_in0/alu_in1  operands A/B (B[4:0] is the shift amount)
//   alu_op_select    opcode (ALU_OP_*)
//   busy             high while a MUL is in flight
//   done             one-cycle pulse, result/zero valid
//   result, zero     registered result and result==0 flag
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MUL_STEPS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        alu_in0,
  input  logic [WIDTH-1:0]        alu_in1,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_select,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic                    zero
);

  alu_state_e       r_state;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [WIDTH-1:0] w_single;
  logic             w_mul_load;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  always_comb begin
    w_single = '0;
    unique case (alu_op_select)
      ALU_OP_ADD: w_single = alu_in0 + alu_in1;
      ALU_OP_SUB: w_single = alu_in0 - alu_in1;
      ALU_OP_AND: w_single = alu_in0 & alu_in1;
      ALU_OP_OR:  w_single = alu_in0 | alu_in1;
      ALU_OP_XOR: w_single = alu_in0 ^ alu_in1;
      ALU_OP_SHL: w_single = alu_in0 << alu_in1[4:0];
      ALU_OP_SHR: w_single = alu_in0 >> alu_in1[4:0];
      ALU_OP_MUL: w_single = '0;  // handled by the multiplier
      default:    w_single = '0;
    endcase
  end

  // A start seen outside StIdle is dropped: no latch, no state change.
  assign w_mul_load = (r_state == StIdle) && start && (alu_op_select == ALU_OP_MUL);

  seq_multiplier #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_mul_load),
    .a          (alu_in0),
    .b          (alu_in1),
    .busy       (w_mul_busy),
    .done       (w_mul_done),
    .product_lo (w_mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (alu_op_select == ALU_OP_MUL) begin
              r_state <= StMulRun;
            end else begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
              r_done   <= 1'b1;
            end
          end
        end
        StMulRun: begin
          if (w_mul_done) begin
            r_result <= w_mul_prod;
            r_zero   <= (w_mul_prod == '0);
            r_done   <= 1'b1;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // The multiplier's busy is registered and tracks StMulRun exactly.
  assign busy   = w_mul_busy;
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

endmodule
